// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package loader_pkg;

  // Start-of-frame marker that opens every program download.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

  // A frame is in flight while the length, payload or checksum is being received.
  function automatic logic is_busy(input ld_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start check, mid-bit data/stop sampling.
// Latency: byte_valid/frame_err pulse ~2 cycles after the middle of the stop bit.
// Backpressure: none; each pulse lasts one cycle and is lost if the consumer is not looking.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] byte_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP,
    U_WAIT
  } urx_state_t;

  urx_state_t       ust;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign rx_s = sync[1];

  // Synchronise the line, then walk start/data/stop bits sampling at mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync       <= 2'b11;
      ust        <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (ust)
        U_IDLE: begin
          cnt <= '0;
          if (!rx_s) ust <= U_START;
        end
        U_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A glitch shorter than half a bit is not a start bit.
            ust     <= rx_s ? U_IDLE : U_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) ust <= U_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              ust        <= U_IDLE;
            end else begin
              // Bad stop bit: drop the byte and wait for the line to idle
              // so the low stop bit is not mistaken for a new start bit.
              frame_err <= 1'b1;
              ust       <= U_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_WAIT: begin
          if (rx_s) ust <= U_IDLE;
        end
        default: ust <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// UART program loader: receives A5/len/words[/csum] frames and writes instruction memory; optional checksum via LOADER_CHECKSUM_EN.
// Latency: wren one cycle after the last byte of each word; done one cycle after the final write (or checksum byte).
// Backpressure: none; memory is assumed to accept one write per cycle, UART bytes cannot be stalled.
module prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NB   = DATA_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BI_W-1:0] LAST_BI = BI_W'(NB - 1);

  logic       byte_valid;
  logic       frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .byte_data (byte_data)
  );

  ld_state_t       state;
  ld_state_t       state_n;
  logic [8:0]      len;       // word count, 0x00 on the wire means 256
  logic [8:0]      word_cnt;  // words already written in this frame
  logic [BI_W-1:0] byte_idx;
  logic            last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign last_word = (word_cnt + 9'd1) == len;

  // Next-state decision; outputs below are registered from it.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: begin
        // Line errors outside a frame carry no information and are ignored.
        if (byte_valid && (byte_data == HDR_BYTE)) state_n = LEN;
      end
      LEN: begin
        if (frame_err) state_n = ERR;
        else if (byte_valid) state_n = DATA;
      end
      DATA: begin
        if (frame_err) state_n = ERR;
`ifdef LOADER_CHECKSUM_EN
        else if (wren && last_word) state_n = CSUM;
`else
        else if (wren && last_word) state_n = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (frame_err) state_n = ERR;
        else if (byte_valid) state_n = (byte_data == csum) ? DONE : ERR;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // State register, registered status outputs and word assembly/write datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wren      <= 1'b0;
      wraddress <= '0;
      data      <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_n;
      busy      <= is_busy(state_n);
      done      <= (state_n == DONE);
      error     <= (state_n == ERR);
      cpu_reset <= (state_n != DONE);
      wren      <= 1'b0;
      case (state)
        LEN: begin
          if (byte_valid) begin
            len       <= {byte_data == 8'd0, byte_data};
            word_cnt  <= '0;
            byte_idx  <= '0;
            wraddress <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        DATA: begin
          if (byte_valid) begin
            data[8*byte_idx +: 8] <= byte_data;
            byte_idx <= (byte_idx == LAST_BI) ? '0 : byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum + byte_data;
`endif
            // Only a fully assembled word is ever written.
            if (byte_idx == LAST_BI) wren <= 1'b1;
          end
          // The address holds on the final word so a 256-word load ends at 0xFF.
          if (wren && !last_word) begin
            wraddress <= wraddress + 1'b1;
            word_cnt  <= word_cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory word address width.
REQ-003 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 wren  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-008 wraddress  output  ADDR_W  instruction-memory write word address.
REQ-009 data  output  DATA_W  instruction word to write.
REQ-010 cpu_reset  output  1  holds the CPU in reset while no valid program is loaded.
REQ-011 busy  output  1  high while a frame is being received (LEN/DATA/CSUM).
REQ-012 done  output  1  high while a complete program is loaded.
REQ-013 error  output  1  high after an aborted load until the next header.

Function
REQ-014 Frame format SHALL be: header 0xA5, length byte N (words; 0x00 means 256), 4*N data bytes little-endian per word, then the checksum byte (REQ-027).
REQ-015 FSM states SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 IDLE: non-0xA5 bytes ignored; 0xA5 -> LEN.
REQ-017 LEN: the received byte is latched as the word count; word index and byte index cleared -> DATA.
REQ-018 DATA: byte k of a word SHALL load data[8k+7:8k]; on the 4th byte, wren pulses high the next cycle with the assembled data and wraddress = word index.
REQ-019 wraddress SHALL increment the cycle after each wren; first write of a frame at address 0; N=256 ends at 0xFF with no wrap.
REQ-020 After the last word's wren: -> DONE if CHECKSUM disabled, else -> CSUM.
REQ-021 DONE: done=1, cpu_reset=0, the cycle after entry; 0xA5 received -> LEN with cpu_reset=1 and done=0 the next cycle.
REQ-022 A UART stop-bit error in LEN, DATA or CSUM SHALL discard the byte -> ERR; partial words are never written.
REQ-023 ERR: error=1, cpu_reset=1, no writes; 0xA5 -> LEN and clears error; in IDLE/DONE stop-bit errors are ignored.
REQ-024 busy SHALL equal (state in LEN, DATA, CSUM).

Reset
REQ-025 On reset: state IDLE, wren=0, wraddress=0, data=0, cpu_reset=1, busy=0, done=0, error=0, uart_rx idle.
REQ-026 Reset mid-frame SHALL abandon the frame with no further write; a pending wren is cancelled.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined: the CSUM state receives one byte compared with the 8-bit modulo-256 sum of all data bytes; match -> DONE, mismatch -> ERR (memory already written, cpu_reset stays 1).
REQ-028 Without LOADER_CHECKSUM_EN: no CSUM state and no checksum byte; the byte following the data is treated as in DONE.

Structure
REQ-029 Package loader_pkg SHALL hold the state enum typedef and the HDR_BYTE = 8'hA5 constant.
REQ-030 Sub-module uart_rx SHALL contain a 2-flop synchroniser, mid-bit start check, mid-bit sampling, and one-cycle byte_valid/frame_err pulses with an 8-bit byte output.

Verification
REQ-031 Checksum off: A5 02 78 56 34 12 EF BE AD DE -> wren at addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; then done=1, cpu_reset=0.
REQ-032 Bytes 00 FF 3C, then the REQ-031 frame -> noise produces no writes; result identical to REQ-031.
REQ-033 A5 00 followed by 1024 bytes -> exactly 256 wren, addresses 0x00..0xFF in order, then done=1.
REQ-034 Stop bit = 0 on the 3rd data byte -> error=1, cpu_reset=1, zero wren; a following valid frame loads and clears error.
REQ-035 LOADER_CHECKSUM_EN: REQ-031 frame plus 4C -> done=1; plus 4D -> error=1, cpu_reset=1.
REQ-036 reset asserted after 6 data bytes of the REQ-031 frame -> one write (addr 0) only; all outputs at reset values; no write for addr 1.
